ldpc_iter_ctrl: RTL

LDPC_ITER_CTRL -- requirements
Module: ldpc_iter_ctrl

---
 rtl/ldpc_iter_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for a layered LDPC decoder: sequences load, check-node and
// variable-node phases, requests syndrome checks, and terminates on convergence, limit or abort.
module ldpc_iter_ctrl #(
  parameter int ITER_W = 6,
  parameter int CN_CYC = 2,
  parameter int VN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              syn_valid,
  input  logic              syn_zero,
  output logic              ld_en,
  output logic              cn_en,
  output logic              vn_en,
  output logic              syn_req,
  output logic              busy,
  output logic              done,
  output logic              success,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam int PH_MAX = (CN_CYC > VN_CYC) ? CN_CYC : VN_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] CN_LAST = PH_W'(CN_CYC - 1);
  localparam logic [PH_W-1:0] VN_LAST = PH_W'(VN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CN,
    S_VN,
    S_SYN,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [ITER_W-1:0] lim_q, lim_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              succ_q, succ_d;
  logic              ld_q, cn_q, vn_q, sreq_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    lim_d   = lim_q;
    iter_d  = iter_q;
    succ_d  = succ_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          lim_d   = (max_iter == '0) ? ITER_W'(1) : max_iter;
          iter_d  = '0;
          succ_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_FIN;
        end else begin
          state_d = S_CN;
          ph_d    = '0;
        end
      end
      S_CN: begin
        if (abort) begin
          state_d = S_FIN;
        end else if (ph_q == CN_LAST) begin
          state_d = S_VN;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_VN: begin
        if (abort) begin
          state_d = S_FIN;
        end else if (ph_q == VN_LAST) begin
          state_d = S_SYN;
          if (iter_q != '1) iter_d = iter_q + ITER_W'(1);
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_SYN: begin
        // abort outranks a syndrome result arriving in the same cycle
        if (abort) begin
          state_d = S_FIN;
        end else if (syn_valid) begin
          if (syn_zero) begin
            state_d = S_FIN;
            succ_d  = 1'b1;
          end else if (iter_q >= lim_q) begin
            state_d = S_FIN;
          end else begin
            state_d = S_CN;
            ph_d    = '0;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      lim_q   <= '0;
      iter_q  <= '0;
      succ_q  <= 1'b0;
      ld_q    <= 1'b0;
      cn_q    <= 1'b0;
      vn_q    <= 1'b0;
      sreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      lim_q   <= lim_d;
      iter_q  <= iter_d;
      succ_q  <= succ_d;
      ld_q    <= (state_d == S_LOAD);
      cn_q    <= (state_d == S_CN);
      vn_q    <= (state_d == S_VN);
      sreq_q  <= (state_d == S_SYN) && (state_q != S_SYN);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FIN);
    end
  end

  assign ld_en    = ld_q;
  assign cn_en    = cn_q;
  assign vn_en    = vn_q;
  assign syn_req  = sreq_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign success  = succ_q;
  assign iter_cnt = iter_q;

endmodule
